// File: rtl/csr_unit_mw_if.sv
// MW-stage CSR/trap bus between the pipeline and csr_unit_mw.
interface csr_unit_mw_if;
  logic        insn_valid_mw;
  logic        csr_rf_rd_mw;
  logic        csr_rf_wr_mw;
  logic [11:0] csr_addr_mw;
  logic [31:0] csr_wdata_mw;
  logic [31:0] pc_mw;
  logic        is_mret_mw;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        epc_taken;
  logic [31:0] epc_pc;

  modport master (
    output insn_valid_mw, csr_rf_rd_mw, csr_rf_wr_mw, csr_addr_mw, csr_wdata_mw,
           pc_mw, is_mret_mw, timer_irq, ext_irq,
    input  csr_rdata, csr_illegal, epc_taken, epc_pc
  );
  modport slave (
    input  insn_valid_mw, csr_rf_rd_mw, csr_rf_wr_mw, csr_addr_mw, csr_wdata_mw,
           pc_mw, is_mret_mw, timer_irq, ext_irq,
    output csr_rdata, csr_illegal, epc_taken, epc_pc
  );
endinterface

// File: rtl/csr_unit_mw.sv
// Machine-mode CSR file and trap/mret sequencer at the MW stage.
module csr_unit_mw #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HARTID      = 32'h0
) (
  input logic          clk,
  input logic          rst,
  csr_unit_mw_if.slave bus
);
  logic        mie_q, mpie_q, mtie_q, meie_q, mtip_q, meip_q, rst_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic        valid, rd_en, wr_en, impl, ro, blk, irq_ext, irq_tmr, trap, mret, wr_ok;
  logic [4:0]  cause_code;
  logic [31:0] rval, tvec_base;
  logic [11:0] addr;
  logic [31:0] wdata;

  assign valid = bus.insn_valid_mw;
  assign addr  = bus.csr_addr_mw;
  assign wdata = bus.csr_wdata_mw;
  assign rd_en = valid & bus.csr_rf_rd_mw;
  assign wr_en = valid & bus.csr_rf_wr_mw;

  always_comb begin
    rval = '0;
    impl = 1'b1;
    ro   = 1'b0;
    case (addr)
      12'h300: rval = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      12'h304: rval = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
      12'h305: rval = mtvec_q;
      12'h340: rval = mscratch_q;
      12'h341: rval = mepc_q;
      12'h342: rval = mcause_q;
      12'h344: begin rval = {20'b0, meip_q, 3'b0, mtip_q, 7'b0}; ro = 1'b1; end
      12'hB00: rval = mcycle_q[31:0];
      12'hB80: rval = mcycle_q[63:32];
      12'hB02: rval = minstret_q[31:0];
      12'hB82: rval = minstret_q[63:32];
      12'hF14: begin rval = HARTID; ro = 1'b1; end
      default: impl = 1'b0;
    endcase
  end

  assign bus.csr_illegal = (rd_en | wr_en) & (~impl | (wr_en & ro));
  assign bus.csr_rdata   = rd_en ? rval : 32'h0;

  // blk suppresses redirects during reset and the cycle right after it
  assign blk        = rst | rst_q;
  assign irq_ext    = meie_q & meip_q;
  assign irq_tmr    = mtie_q & mtip_q;
  assign trap       = ~blk & valid & mie_q & (irq_ext | irq_tmr);
  assign mret       = ~blk & valid & bus.is_mret_mw & ~trap;
  assign cause_code = irq_ext ? 5'd11 : 5'd7;
  assign wr_ok      = wr_en & ~bus.csr_illegal & ~trap;
  assign tvec_base  = {mtvec_q[31:2], 2'b00};

  assign bus.epc_taken = trap | mret;
  assign bus.epc_pc    = trap ? ((mtvec_q[1:0] == 2'b01) ? tvec_base + {25'b0, cause_code, 2'b00}
                                                         : tvec_base)
                              : mepc_q;

  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, valid & ~trap};
    if (wr_ok) begin
      case (addr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], wdata};
        12'hB80: mcycle_d   = {wdata, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wdata};
        12'hB82: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      rst_q      <= 1'b0;
      mtip_q     <= bus.timer_irq;
      meip_q     <= bus.ext_irq;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (trap) begin
        mepc_q   <= bus.pc_mw;
        mcause_q <= {1'b1, 26'b0, cause_code};
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr_ok) begin
        case (addr)
          12'h300: begin mie_q <= wdata[3]; mpie_q <= wdata[7]; end
          12'h304: begin mtie_q <= wdata[7]; meie_q <= wdata[11]; end
          12'h305: mtvec_q    <= wdata;
          12'h340: mscratch_q <= wdata;
          12'h341: mepc_q     <= {wdata[31:2], 2'b00};
          12'h342: mcause_q   <= wdata;
          default: ;
        endcase
      end
    end
  end
endmodule
